rx_chan_router: RTL and testbench

// - Control/data-plane successor to the fixed 3-path RX core: N DDC->DUC channels, M DAC outputs, runtime routing.
// - Holds staged and active DDC/DUC phase increments, channel enables and per-DAC source routing.
// - Applies staged config atomically via a commit FSM that mutes DAC outputs while DSP paths flush.
// - Sits between the sysgen RX DSP core / iq_freq_shift instances and the DAC sample buses.

---
 rtl/rx_chan_pkg.sv | 27 ++
 rtl/rx_route_mux.sv | 45 ++++
 rtl/rx_chan_router.sv | 143 ++++++++++++++
 tb/tb_rx_chan_router.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_chan_pkg.sv
// Shared types and constants for the multi-channel RX router.
// The DSP-facing pinc width is fixed here so the channel record stays a plain packed struct.
package rx_chan_pkg;

  localparam int PINC_W = 16;

  localparam logic CFG_SEL_CHAN = 1'b0;
  localparam logic CFG_SEL_DAC  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUTE  = 2'd1,
    FLUSH = 2'd2
  } commit_state_e;

  typedef struct packed {
    logic [PINC_W-1:0] ddc_pinc;
    logic [PINC_W-1:0] duc_pinc;
    logic              enable;
  } chan_cfg_t;

  // Index width that never collapses to zero bits for single-entry tables.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_route_mux.sv
// One DAC output: registered NUM_CHANNELS:1 sample select with mute and disabled-channel zeroing.
module rx_route_mux
  import rx_chan_pkg::*;
#(
  parameter int NUMBER_OF_LINE = 8,
  parameter int NUM_CHANNELS   = 4,
  parameter int RW             = 2
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   mute,
  input  logic [RW-1:0]                          sel,
  input  logic [NUM_CHANNELS-1:0]                en_vec,
  input  logic [NUM_CHANNELS*16*NUMBER_OF_LINE-1:0] chan_data,
  output logic [16*NUMBER_OF_LINE-1:0]           dac_data
);

  localparam int SW = 16 * NUMBER_OF_LINE;

  logic [SW-1:0] pick_next;
  logic [SW-1:0] dac_reg;

  // A select beyond the channel count matches no entry and therefore yields zero.
  always_comb begin
    pick_next = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (sel == RW'(k) && en_vec[k]) begin
        pick_next = chan_data[k*SW +: SW];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dac_reg <= '0;
    end else if (mute) begin
      dac_reg <= '0;
    end else begin
      dac_reg <= pick_next;
    end
  end

  assign dac_data = dac_reg;

endmodule

// File: rtl/rx_chan_router.sv
// Runtime channel/DAC router: staged and active config register files, a commit FSM that
// mutes all DAC outputs while the DSP paths flush, and one registered route mux per DAC.
module rx_chan_router
  import rx_chan_pkg::*;
#(
  parameter int NUMBER_OF_LINE = 8,
  parameter int NUM_CHANNELS   = 4,
  parameter int NUM_DAC        = 3,
  parameter int PINC_WIDTH     = PINC_W,
  parameter int FLUSH_CYCLES   = 16,
  localparam int CW = idx_width((NUM_CHANNELS > NUM_DAC) ? NUM_CHANNELS : NUM_DAC),
  localparam int RW = idx_width(NUM_CHANNELS)
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       cfg_valid,
  output logic                                       cfg_ready,
  input  logic                                       cfg_sel,
  input  logic [CW-1:0]                              cfg_addr,
  input  logic [PINC_WIDTH-1:0]                      cfg_ddc_pinc,
  input  logic [PINC_WIDTH-1:0]                      cfg_duc_pinc,
  input  logic                                       cfg_enable,
  input  logic [RW-1:0]                              cfg_route,
  input  logic                                       commit,
  output logic                                       commit_busy,
  output logic                                       commit_done,
  output logic [NUM_CHANNELS*PINC_WIDTH-1:0]         ddc_pinc,
  output logic [NUM_CHANNELS*PINC_WIDTH-1:0]         duc_pinc,
  output logic                                       dsp_phase_rst,
  input  logic [NUM_CHANNELS*16*NUMBER_OF_LINE-1:0]  chan_data,
  output logic [NUM_DAC*16*NUMBER_OF_LINE-1:0]       dac_data
);

  localparam int SW = 16 * NUMBER_OF_LINE;
  localparam int FW = idx_width(FLUSH_CYCLES);
  localparam chan_cfg_t CHAN_RST = '{ddc_pinc: '0, duc_pinc: '0, enable: 1'b1};

  commit_state_e state_reg, state_next;
  logic [FW-1:0] flush_cnt_reg, flush_cnt_next;

  chan_cfg_t         stg_chan_reg  [NUM_CHANNELS];
  chan_cfg_t         act_chan_reg  [NUM_CHANNELS];
  logic [RW-1:0]     stg_route_reg [NUM_DAC];
  logic [RW-1:0]     act_route_reg [NUM_DAC];
  logic [NUM_CHANNELS-1:0] en_act;

  logic wr_en, chan_wr, dac_wr, mute;

  assign cfg_ready     = (state_reg == IDLE) && !reset;
  assign commit_busy   = (state_reg != IDLE) && !reset;
  assign dsp_phase_rst = (state_reg == MUTE) && !reset;
  assign commit_done   = (state_reg == FLUSH) && (flush_cnt_reg == '0) && !reset;

  assign wr_en   = cfg_valid && cfg_ready;
  assign chan_wr = wr_en && (cfg_sel == CFG_SEL_CHAN);
  assign dac_wr  = wr_en && (cfg_sel == CFG_SEL_DAC);
  assign mute    = (state_reg != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (commit) state_next = MUTE;
      end
      MUTE: begin
        flush_cnt_next = FW'(FLUSH_CYCLES - 1);
        state_next     = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          flush_cnt_next = flush_cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Addresses past the table end match no generate slot, so such writes vanish silently.
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    always_ff @(posedge clock) begin
      if (reset) begin
        stg_chan_reg[gi] <= CHAN_RST;
        act_chan_reg[gi] <= CHAN_RST;
      end else begin
        if (chan_wr && cfg_addr == CW'(gi)) begin
          stg_chan_reg[gi] <= '{ddc_pinc: cfg_ddc_pinc, duc_pinc: cfg_duc_pinc,
                                enable: cfg_enable};
        end
        if (state_reg == MUTE) begin
          act_chan_reg[gi] <= stg_chan_reg[gi];
        end
      end
    end

    assign ddc_pinc[gi*PINC_WIDTH +: PINC_WIDTH] = act_chan_reg[gi].ddc_pinc;
    assign duc_pinc[gi*PINC_WIDTH +: PINC_WIDTH] = act_chan_reg[gi].duc_pinc;
    assign en_act[gi] = act_chan_reg[gi].enable;
  end

  for (genvar gi = 0; gi < NUM_DAC; gi++) begin : g_dac
    always_ff @(posedge clock) begin
      if (reset) begin
        stg_route_reg[gi] <= RW'(gi % NUM_CHANNELS);
        act_route_reg[gi] <= RW'(gi % NUM_CHANNELS);
      end else begin
        if (dac_wr && cfg_addr == CW'(gi)) begin
          stg_route_reg[gi] <= cfg_route;
        end
        if (state_reg == MUTE) begin
          act_route_reg[gi] <= stg_route_reg[gi];
        end
      end
    end

    rx_route_mux #(
      .NUMBER_OF_LINE (NUMBER_OF_LINE),
      .NUM_CHANNELS   (NUM_CHANNELS),
      .RW             (RW)
    ) u_mux (
      .clock     (clock),
      .reset     (reset),
      .mute      (mute),
      .sel       (act_route_reg[gi]),
      .en_vec    (en_act),
      .chan_data (chan_data),
      .dac_data  (dac_data[gi*SW +: SW])
    );
  end

endmodule

// File: tb/tb_rx_chan_router.sv
// Directed bench for rx_chan_router: stimulus queues cycle-stamped expectations,
// a negedge monitor compares them against the live outputs.
module tb_rx_chan_router;

  localparam int NL   = 8;
  localparam int NCH  = 4;
  localparam int NDAC = 3;
  localparam int PW   = 16;
  localparam int FC   = 16;
  localparam int SW   = 16 * NL;

  logic              clock = 1'b0;
  logic              reset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_sel;
  logic [1:0]        cfg_addr;
  logic [PW-1:0]     cfg_ddc_pinc;
  logic [PW-1:0]     cfg_duc_pinc;
  logic              cfg_enable;
  logic [1:0]        cfg_route;
  logic              commit;
  logic              commit_busy;
  logic              commit_done;
  logic [NCH*PW-1:0] ddc_pinc;
  logic [NCH*PW-1:0] duc_pinc;
  logic              dsp_phase_rst;
  logic [NCH*SW-1:0] chan_data;
  logic [NDAC*SW-1:0] dac_data;

  always #5 clock = ~clock;

  rx_chan_router #(
    .NUMBER_OF_LINE (NL),
    .NUM_CHANNELS   (NCH),
    .NUM_DAC        (NDAC),
    .PINC_WIDTH     (PW),
    .FLUSH_CYCLES   (FC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_sel       (cfg_sel),
    .cfg_addr      (cfg_addr),
    .cfg_ddc_pinc  (cfg_ddc_pinc),
    .cfg_duc_pinc  (cfg_duc_pinc),
    .cfg_enable    (cfg_enable),
    .cfg_route     (cfg_route),
    .commit        (commit),
    .commit_busy   (commit_busy),
    .commit_done   (commit_done),
    .ddc_pinc      (ddc_pinc),
    .duc_pinc      (duc_pinc),
    .dsp_phase_rst (dsp_phase_rst),
    .chan_data     (chan_data),
    .dac_data      (dac_data)
  );

  typedef enum int {K_DAC, K_DDC, K_DUC, K_DONE, K_BUSY, K_READY, K_PRST} kind_e;
  typedef struct {
    int    at;
    kind_e kind;
    int    idx;
    int    val;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_one(input exp_t e);
    int act;
    int lv;
    act = 0;
    case (e.kind)
      K_DAC: begin
        // All lanes must carry the expected sample; report the first lane that does not.
        act = int'(dac_data[e.idx*SW +: 16]);
        for (int l = 0; l < NL; l++) begin
          lv = int'(dac_data[e.idx*SW + l*16 +: 16]);
          if (lv != e.val) begin
            act = lv;
            break;
          end
        end
      end
      K_DDC:   act = int'(ddc_pinc[e.idx*PW +: PW]);
      K_DUC:   act = int'(duc_pinc[e.idx*PW +: PW]);
      K_DONE:  act = int'(commit_done);
      K_BUSY:  act = int'(commit_busy);
      K_READY: act = int'(cfg_ready);
      K_PRST:  act = int'(dsp_phase_rst);
      default: act = -1;
    endcase
    n_checks++;
    if (act == e.val) begin
      n_pass++;
      $display("check %s cyc %0d value 0x%0h ok", e.name, cyc, act);
    end else begin
      $display("FAIL %s cyc %0d got 0x%0h expected 0x%0h", e.name, cyc, act, e.val);
    end
  endtask

  always @(negedge clock) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].at == cyc) begin
        check_one(exp_q[i]);
        exp_q.delete(i);
      end
    end
  end

  task automatic expect_at(input int at, input kind_e k, input int idx, input int val,
                           input string nm);
    exp_t e;
    e.at = at; e.kind = k; e.idx = idx; e.val = val; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic cfg_write(input logic sel, input logic [1:0] addr, input logic [15:0] ddc,
                           input logic [15:0] duc, input logic en, input logic [1:0] route);
    cfg_valid    = 1'b1;
    cfg_sel      = sel;
    cfg_addr     = addr;
    cfg_ddc_pinc = ddc;
    cfg_duc_pinc = duc;
    cfg_enable   = en;
    cfg_route    = route;
  endtask

  // Commit pulse sampled at edge e+1: MUTE at e+1, FLUSH e+2..e+17, IDLE from e+18;
  // the registered DAC output is zero for e+2..e+18 and shows the new route at e+19.
  task automatic commit_window(input int e, input int dac_idx, input int old_v,
                               input int new_v, input string tag);
    expect_at(e,      K_BUSY,  0, 0, {tag, "_busy_pre"});
    expect_at(e + 1,  K_BUSY,  0, 1, {tag, "_busy_mute"});
    expect_at(e + 17, K_BUSY,  0, 1, {tag, "_busy_last"});
    expect_at(e + 18, K_BUSY,  0, 0, {tag, "_busy_post"});
    expect_at(e + 1,  K_PRST,  0, 1, {tag, "_prst_mute"});
    expect_at(e + 2,  K_PRST,  0, 0, {tag, "_prst_flush"});
    expect_at(e + 10, K_READY, 0, 0, {tag, "_ready_flush"});
    expect_at(e + 18, K_READY, 0, 1, {tag, "_ready_idle"});
    for (int c = e + 1; c <= e + 16; c++) expect_at(c, K_DONE, 0, 0, {tag, "_done_lo"});
    expect_at(e + 17, K_DONE,  0, 1, {tag, "_done_pulse"});
    expect_at(e + 18, K_DONE,  0, 0, {tag, "_done_after"});
    expect_at(e,      K_DAC, dac_idx, old_v, {tag, "_dac_pre0"});
    expect_at(e + 1,  K_DAC, dac_idx, old_v, {tag, "_dac_pre1"});
    expect_at(e + 2,  K_DAC, dac_idx, 0,     {tag, "_dac_mute_first"});
    expect_at(e + 10, K_DAC, dac_idx, 0,     {tag, "_dac_mute_mid"});
    expect_at(e + 18, K_DAC, dac_idx, 0,     {tag, "_dac_mute_last"});
    expect_at(e + 19, K_DAC, dac_idx, new_v, {tag, "_dac_new"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    reset = 1'b1;
    commit = 1'b0;
    cfg_valid = 1'b0; cfg_sel = 1'b0; cfg_addr = '0;
    cfg_ddc_pinc = '0; cfg_duc_pinc = '0; cfg_enable = 1'b0; cfg_route = '0;
    for (int k = 0; k < NCH; k++)
      for (int l = 0; l < NL; l++)
        chan_data[k*SW + l*16 +: 16] = 16'(16'h1000 * (k + 1));

    // Reset state and first routed samples.
    expect_at(2, K_READY, 0, 0, "rst_ready");
    expect_at(2, K_BUSY,  0, 0, "rst_busy");
    expect_at(2, K_DONE,  0, 0, "rst_done");
    expect_at(2, K_PRST,  0, 0, "rst_prst");
    expect_at(2, K_DAC,   0, 0, "rst_dac0");
    expect_at(2, K_DDC,   0, 0, "rst_ddc0");
    expect_at(2, K_DUC,   3, 0, "rst_duc3");
    expect_at(3, K_READY, 0, 1, "rel_ready");
    expect_at(4, K_DAC,   0, 16'h1000, "def_dac0");
    expect_at(4, K_DAC,   1, 16'h2000, "def_dac1");
    expect_at(4, K_DAC,   2, 16'h3000, "def_dac2");
    repeat (3) tick();
    reset = 1'b0;
    tick(); tick();

    // Reroute DAC0 to channel 3.
    cfg_write(1'b1, 2'd0, 16'h0, 16'h0, 1'b0, 2'd3);
    tick();
    cfg_valid = 1'b0;
    commit = 1'b1;
    e = cyc;
    commit_window(e, 0, 16'h1000, 16'h4000, "route");
    expect_at(e + 19, K_DAC, 1, 16'h2000, "route_dac1_kept");
    tick();
    commit = 1'b0;
    wait_until(e + 21);

    // Channel 2 pincs and disable.
    cfg_write(1'b0, 2'd2, 16'h1234, 16'h0800, 1'b0, 2'd0);
    tick();
    cfg_valid = 1'b0;
    commit = 1'b1;
    e = cyc;
    commit_window(e, 2, 16'h3000, 0, "chan2");
    expect_at(e,      K_DDC, 2, 0,        "chan2_ddc_staged_only");
    expect_at(e + 2,  K_DDC, 2, 16'h1234, "chan2_ddc_active");
    expect_at(e + 2,  K_DUC, 2, 16'h0800, "chan2_duc_active");
    expect_at(e + 19, K_DAC, 0, 16'h4000, "chan2_dac0_kept");
    expect_at(e + 25, K_DAC, 2, 0,        "chan2_dac2_off");
    tick();
    commit = 1'b0;
    wait_until(e + 21);

    // Commit and config write attempted mid-flush are ignored.
    commit = 1'b1;
    e = cyc;
    commit_window(e, 0, 16'h4000, 16'h4000, "reflush");
    tick();
    commit = 1'b0;
    wait_until(e + 5);
    expect_at(e + 5, K_READY, 0, 0, "flush_ready_low");
    cfg_write(1'b0, 2'd0, 16'hBEEF, 16'hBEEF, 1'b1, 2'd0);
    commit = 1'b1;
    tick();
    cfg_valid = 1'b0;
    commit = 1'b0;
    for (int c = e + 19; c <= e + 22; c++) begin
      expect_at(c, K_DONE, 0, 0, "flush_no_extra_done");
      expect_at(c, K_BUSY, 0, 0, "flush_no_recommit");
    end
    wait_until(e + 23);

    // Out-of-range DAC address is dropped; write + commit in the same cycle lands.
    cfg_write(1'b1, 2'd3, 16'h0, 16'h0, 1'b0, 2'd1);
    tick();
    cfg_write(1'b0, 2'd1, 16'h0000, 16'h00FF, 1'b1, 2'd0);
    commit = 1'b1;
    e = cyc;
    commit_window(e, 0, 16'h4000, 16'h4000, "wrcommit");
    expect_at(e + 1,  K_DUC, 1, 0,        "wrcommit_duc1_pre");
    expect_at(e + 2,  K_DUC, 1, 16'h00FF, "wrcommit_duc1_new");
    expect_at(e + 2,  K_DDC, 0, 0,        "ignored_write_ddc0");
    expect_at(e + 2,  K_DDC, 2, 16'h1234, "wrcommit_ddc2_kept");
    expect_at(e + 19, K_DAC, 1, 16'h2000, "oor_dac1_kept");
    expect_at(e + 19, K_DAC, 2, 0,        "oor_dac2_still_off");
    tick();
    cfg_valid = 1'b0;
    commit = 1'b0;
    wait_until(e + 21);

    // Reset asserted while the flush counter reads 5.
    commit = 1'b1;
    e = cyc;
    expect_at(e + 1,  K_BUSY, 0, 1, "rstmid_busy");
    expect_at(e + 1,  K_PRST, 0, 1, "rstmid_prst");
    expect_at(e + 11, K_DDC,  2, 16'h1234, "rstmid_ddc2_pre");
    tick();
    commit = 1'b0;
    wait_until(e + 12);
    reset = 1'b1;
    expect_at(e + 12, K_BUSY,  0, 0, "rstmid_busy_in_rst");
    expect_at(e + 12, K_PRST,  0, 0, "rstmid_prst_in_rst");
    expect_at(e + 12, K_READY, 0, 0, "rstmid_ready_in_rst");
    tick();
    reset = 1'b0;
    expect_at(e + 13, K_BUSY,  0, 0, "rstmid_idle");
    expect_at(e + 13, K_READY, 0, 1, "rstmid_ready");
    expect_at(e + 13, K_PRST,  0, 0, "rstmid_prst_after");
    expect_at(e + 13, K_DDC,   2, 0, "rstmid_ddc2_dflt");
    expect_at(e + 13, K_DUC,   1, 0, "rstmid_duc1_dflt");
    expect_at(e + 13, K_DAC,   0, 0, "rstmid_dac0_cleared");
    expect_at(e + 14, K_DAC,   0, 16'h1000, "rstmid_dac0_dflt_route");
    expect_at(e + 14, K_DAC,   2, 16'h3000, "rstmid_dac2_reenabled");
    for (int c = e + 13; c <= e + 20; c++) expect_at(c, K_DONE, 0, 0, "rstmid_no_done");
    wait_until(e + 21);

    // Staging also returned to defaults: an empty commit keeps defaults active.
    commit = 1'b1;
    e = cyc;
    expect_at(e + 2,  K_DDC, 2, 0,        "restage_ddc2");
    expect_at(e + 2,  K_DUC, 1, 0,        "restage_duc1");
    expect_at(e + 17, K_DONE, 0, 1,       "restage_done");
    expect_at(e + 19, K_DAC, 0, 16'h1000, "restage_dac0");
    expect_at(e + 19, K_DAC, 2, 16'h3000, "restage_dac2");
    tick();
    commit = 1'b0;
    wait_until(e + 21);
    tick(); tick();

    while (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL %s never sampled (due cyc %0d, now %0d) expected 0x%0h",
               exp_q[0].name, exp_q[0].at, cyc, exp_q[0].val);
      void'(exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
